// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory image loader: loader FSM
// state encoding and default geometry/timeout parameters.
package imem_ctrl_pkg;

    localparam int IMEM_AW_DEF = 8;
    localparam int TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        WRITE = 2'd3
    } ld_state_e;

endpackage

// File: rtl/ld_timer.sv
// Per-word wait watchdog: counts cycles while enabled and flags the
// TIMEOUT-th enabled cycle since the last clear.
module ld_timer
    import imem_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    assign expired = enable && (count_q == LAST);

    // Next count: clear wins, otherwise advance while waiting, saturating at LAST.
    always_comb begin
        if (clear) begin
            count_d = {CW{1'b0}};
        end else if (enable && !expired) begin
            count_d = count_q + CW'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= {CW{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/imem_load_ctrl.sv
// Instruction-memory loader: copies an image word by word from an external
// source into IMEM, then serves core fetches from IMEM while idle.
module imem_load_ctrl
    import imem_ctrl_pkg::*;
#(
    parameter int IMEM_AW = IMEM_AW_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load_start,
    input  logic [IMEM_AW:0]   load_words,
    output logic               exIns_ren,
    output logic [31:0]        exIns_addr,
    input  logic               exIns_valid,
    input  logic [31:0]        exIns_in,
    input  logic               core_fetch_req,
    input  logic [31:0]        core_fetch_addr,
    output logic               core_fetch_ready,
    output logic               core_fetch_valid,
    output logic [31:0]        core_fetch_data,
    output logic               imem_en,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    input  logic [31:0]        imem_rdata,
    output logic               core_hold,
    output logic               busy,
    output logic               done,
    output logic               err
);

    localparam logic [IMEM_AW:0] MAX_WORDS = {1'b1, {IMEM_AW{1'b0}}};
    localparam logic [IMEM_AW:0] ONE_W     = {{IMEM_AW{1'b0}}, 1'b1};

    ld_state_e          state_q, state_d;
    logic [IMEM_AW:0]   idx_q, idx_d;
    logic [IMEM_AW:0]   nwords_q, nwords_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [IMEM_AW-1:0] wr_addr_q, wr_addr_d;
    logic [31:0]        exaddr_q, exaddr_d;
    logic               ren_q, ren_d;
    logic               wr_q, wr_d;
    logic               fvalid_q, fvalid_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
    logic               hold_q, hold_d;
    logic               busy_q, busy_d;

    logic               fetch_acc_s;
    logic [IMEM_AW:0]   words_sat_s;
    logic               tmr_expired_s;
    logic               unused_fetch_bits_s;

    assign words_sat_s         = (load_words > MAX_WORDS) ? MAX_WORDS : load_words;
    assign core_fetch_ready    = !busy_q && !load_start && !rst;
    assign fetch_acc_s         = core_fetch_req && core_fetch_ready;
    assign unused_fetch_bits_s = ^{core_fetch_addr[31:IMEM_AW+2], core_fetch_addr[1:0]};

    ld_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_q == REQ),
        .enable  (state_q == WAIT),
        .expired (tmr_expired_s)
    );

    // Loader FSM next-state and registered-output computation.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        nwords_d  = nwords_q;
        wdata_d   = wdata_q;
        wr_addr_d = wr_addr_q;
        wr_d      = 1'b0;
        done_d    = 1'b0;
        err_d     = err_q;
        hold_d    = hold_q;
        fvalid_d  = fetch_acc_s;
        case (state_q)
            IDLE: begin
                if (load_start) begin
                    err_d = 1'b0;
                    if (words_sat_s == {(IMEM_AW+1){1'b0}}) begin
                        done_d = 1'b1;
                        hold_d = 1'b0;
                    end else begin
                        state_d  = REQ;
                        nwords_d = words_sat_s;
                        idx_d    = {(IMEM_AW+1){1'b0}};
                        hold_d   = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                state_d = WAIT;
            end
            WAIT: begin
                // A word arriving on the expiry cycle is still taken.
                if (exIns_valid) begin
                    state_d   = WRITE;
                    wdata_d   = exIns_in;
                    wr_d      = 1'b1;
                    wr_addr_d = idx_q[IMEM_AW-1:0];
                end else if (tmr_expired_s) begin
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = WAIT;
                end
            end
            WRITE: begin
                idx_d = idx_q + ONE_W;
                if ((idx_q + ONE_W) == nwords_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    state_d = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ren_d  = (state_d == REQ);
        busy_d = (state_d != IDLE);
        if (ren_d) begin
            exaddr_d = {{(30-IMEM_AW){1'b0}}, idx_d[IMEM_AW-1:0], 2'b00};
        end else begin
            exaddr_d = exaddr_q;
        end
    end

    // Loader FSM state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            idx_q     <= {(IMEM_AW+1){1'b0}};
            nwords_q  <= {(IMEM_AW+1){1'b0}};
            wdata_q   <= 32'h0;
            wr_addr_q <= {IMEM_AW{1'b0}};
            exaddr_q  <= 32'h0;
            ren_q     <= 1'b0;
            wr_q      <= 1'b0;
            fvalid_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            hold_q    <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            nwords_q  <= nwords_d;
            wdata_q   <= wdata_d;
            wr_addr_q <= wr_addr_d;
            exaddr_q  <= exaddr_d;
            ren_q     <= ren_d;
            wr_q      <= wr_d;
            fvalid_q  <= fvalid_d;
            done_q    <= done_d;
            err_q     <= err_d;
            hold_q    <= hold_d;
            busy_q    <= busy_d;
        end
    end

    // IMEM port mux: the fetch read must leave in the accept cycle to meet
    // the one-cycle fetch latency, so only the write side is pre-registered.
    always_comb begin
        if (rst) begin
            imem_en    = 1'b0;
            imem_we    = 1'b0;
            imem_addr  = {IMEM_AW{1'b0}};
            imem_wdata = 32'h0;
        end else if (wr_q) begin
            imem_en    = 1'b1;
            imem_we    = 1'b1;
            imem_addr  = wr_addr_q;
            imem_wdata = wdata_q;
        end else if (fetch_acc_s) begin
            imem_en    = 1'b1;
            imem_we    = 1'b0;
            imem_addr  = core_fetch_addr[IMEM_AW+1:2];
            imem_wdata = 32'h0;
        end else begin
            imem_en    = 1'b0;
            imem_we    = 1'b0;
            imem_addr  = {IMEM_AW{1'b0}};
            imem_wdata = 32'h0;
        end
    end

    assign exIns_ren        = ren_q;
    assign exIns_addr       = exaddr_q;
    assign core_fetch_valid = fvalid_q;
    assign core_fetch_data  = fvalid_q ? imem_rdata : 32'h0;
    assign core_hold        = hold_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_imem_load_ctrl.sv
// Self-checking bench for imem_load_ctrl: transaction-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_imem_load_ctrl;

    localparam int AW = 8;
    localparam int TO = 5;

    logic        clk = 1'b0;
    logic        rst, load_start, exIns_valid, core_fetch_req;
    logic [8:0]  load_words;
    logic [31:0] exIns_in, core_fetch_addr, exIns_addr, core_fetch_data, imem_wdata, imem_rdata;
    logic        exIns_ren, core_fetch_ready, core_fetch_valid, imem_en, imem_we;
    logic [7:0]  imem_addr;
    logic        core_hold, busy, done, err;

    int n_checks = 0;
    int n_err    = 0;
    int wr_cnt = 0, done_cnt = 0, ren_cnt = 0, last_wa = -1;

    int src_lat   = 2;    // 0: never answer, -1: random 1..TO+1
    bit src_fixed = 1'b1; // data = 0xA0 + word index
    bit src_spur  = 1'b0;

    logic [31:0] imem_mem [0:255];

    always #5 clk = ~clk;

    imem_load_ctrl #(.IMEM_AW(AW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .load_start(load_start), .load_words(load_words),
        .exIns_ren(exIns_ren), .exIns_addr(exIns_addr), .exIns_valid(exIns_valid),
        .exIns_in(exIns_in), .core_fetch_req(core_fetch_req),
        .core_fetch_addr(core_fetch_addr), .core_fetch_ready(core_fetch_ready),
        .core_fetch_valid(core_fetch_valid), .core_fetch_data(core_fetch_data),
        .imem_en(imem_en), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .imem_rdata(imem_rdata),
        .core_hold(core_hold), .busy(busy), .done(done), .err(err)
    );

    // IMEM: synchronous write, one-cycle read latency
    initial begin
        for (int i = 0; i < 256; i++) imem_mem[i] = 32'h0;
        imem_rdata = 32'h0;
        forever begin
            @(posedge clk);
            if (imem_en && imem_we) imem_mem[imem_addr] <= imem_wdata;
            if (imem_en && !imem_we) imem_rdata <= imem_mem[imem_addr];
        end
    end

    // External word source
    initial begin
        int cnt;
        logic [31:0] pend;
        cnt = 0;
        pend = 32'h0;
        exIns_valid = 1'b0;
        exIns_in = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            exIns_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    exIns_valid = 1'b1;
                    exIns_in = pend;
                end
            end else if (src_spur && $urandom_range(0, 7) == 0) begin
                exIns_valid = 1'b1;
                exIns_in = $urandom;
            end
            if (exIns_ren === 1'b1) begin
                cnt  = (src_lat < 0) ? $urandom_range(1, TO + 1) : src_lat;
                pend = src_fixed ? (32'hA0 + (exIns_addr >> 2)) : $urandom;
            end
        end
    end

    // Reference model and per-cycle comparison
    initial begin
        bit e_ren = 0, e_wr = 0, e_done = 0, e_busy = 0, e_err = 0, e_hold = 1, e_fv = 0;
        logic [31:0] e_addr = 0, e_wd = 0, e_fd = 0;
        int e_wa = 0, m_n = 0, m_idx = 0, m_ren_cyc = 0, cyc = 0, fa, nsat;
        bit armed = 0, rdy, acc, x_en, x_we, n_ren, n_wr, n_done;
        logic [7:0] x_ia;
        logic [112:0] act, exp;
        logic [31:0] m_mem [0:255];
        for (int i = 0; i < 256; i++) m_mem[i] = 32'h0;
        forever begin
            @(negedge clk);
            rdy  = !e_busy && !load_start && !rst;
            acc  = rdy && core_fetch_req;
            fa   = int'(core_fetch_addr[9:2]);
            x_en = !rst && (e_wr || acc);
            x_we = !rst && e_wr;
            x_ia = !x_en ? 8'h0 : (e_wr ? 8'(e_wa) : 8'(fa));
            if (armed) begin
                act = {exIns_ren, (e_ren ? exIns_addr : 32'h0), core_fetch_ready, core_fetch_valid,
                       core_fetch_data, imem_en, imem_we, imem_addr, imem_wdata,
                       core_hold, busy, done, err};
                exp = {e_ren, (e_ren ? e_addr : 32'h0), rdy, e_fv, (e_fv ? e_fd : 32'h0),
                       x_en, x_we, x_ia, (x_we ? e_wd : 32'h0), e_hold, e_busy, e_done, e_err};
                n_checks++;
                if (act !== exp) begin
                    n_err++;
                    $display("FAIL cycle_outputs cyc=%0d got %h expected %h", cyc, act, exp);
                end
            end
            if (!rst) begin
                if (imem_en && imem_we) begin wr_cnt++; last_wa = int'(imem_addr); end
                if (done) done_cnt++;
                if (exIns_ren) ren_cnt++;
            end
            n_ren = 0; n_wr = 0; n_done = 0;
            e_fd = acc ? m_mem[fa] : 32'h0;
            e_fv = acc;
            if (rst) begin
                e_busy = 0; e_err = 0; e_hold = 1; m_idx = 0; e_addr = 0;
            end else if (!e_busy && load_start) begin
                e_err = 0;
                nsat = (int'(load_words) > 256) ? 256 : int'(load_words);
                if (nsat == 0) begin
                    n_done = 1; e_hold = 0;
                end else begin
                    m_n = nsat; m_idx = 0; e_busy = 1; e_hold = 1;
                    n_ren = 1; e_addr = 0; m_ren_cyc = cyc + 1;
                end
            end else if (e_busy) begin
                if (e_wr) begin
                    m_mem[e_wa] = e_wd;
                    m_idx++;
                    if (m_idx == m_n) begin
                        e_busy = 0; n_done = 1; e_hold = 0;
                    end else begin
                        n_ren = 1; e_addr = 32'(m_idx * 4); m_ren_cyc = cyc + 1;
                    end
                end else if (!e_ren) begin
                    if (exIns_valid) begin
                        n_wr = 1; e_wa = m_idx; e_wd = exIns_in;
                    end else if (cyc - m_ren_cyc >= TO) begin
                        e_busy = 0; e_err = 1;
                    end
                end
            end
            e_ren = n_ren; e_wr = n_wr; e_done = n_done;
            cyc++;
            if (rst) armed = 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic start_load(input int n);
        load_words = n[8:0];
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic wait_idle(input int maxc, input string nm);
        int k = 0;
        while (busy !== 1'b0 && k < maxc) begin
            tick();
            k++;
        end
        if (k >= maxc) begin
            n_checks++;
            n_err++;
            $display("FAIL %s: still busy after %0d cycles", nm, maxc);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int bw, bd, br, k;
        rst = 1'b1; load_start = 1'b0; load_words = 9'd0;
        core_fetch_req = 1'b0; core_fetch_addr = 32'h0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_hold", core_hold, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_ren", exIns_ren, 0);
        chk("rst_exaddr", exIns_addr, 0);
        chk("rst_ready", core_fetch_ready, 1);

        // Four-word load, source answers two cycles after each ren
        bw = wr_cnt; bd = done_cnt;
        start_load(4);
        wait_idle(100, "load4");
        tick();
        chk("load4_writes", wr_cnt - bw, 4);
        chk("load4_done", done_cnt - bd, 1);
        chk("load4_hold", core_hold, 0);
        chk("load4_mem0", imem_mem[0], 32'hA0);
        chk("load4_mem3", imem_mem[3], 32'hA3);

        // Fetch from byte address 8
        core_fetch_addr = 32'h8; core_fetch_req = 1'b1;
        #1;
        chk("fetch_ready", core_fetch_ready, 1);
        chk("fetch_imem_addr", imem_addr, 2);
        tick();
        core_fetch_req = 1'b0;
        chk("fetch_valid", core_fetch_valid, 1);
        chk("fetch_data", core_fetch_data, 32'hA2);

        // load_start beats a simultaneous fetch
        load_words = 9'd1; load_start = 1'b1;
        core_fetch_req = 1'b1; core_fetch_addr = 32'h0;
        #1;
        chk("collide_ready", core_fetch_ready, 0);
        tick();
        load_start = 1'b0; core_fetch_req = 1'b0;
        chk("collide_ren", exIns_ren, 1);
        chk("collide_fvalid", core_fetch_valid, 0);
        wait_idle(50, "collide");
        tick();

        // Timeout: no answer from the source
        src_lat = 0;
        bd = done_cnt;
        start_load(3);
        tick();
        k = 0;
        while (busy === 1'b1 && k < 50) begin tick(); k++; end
        chk("to_wait_cycles", k, TO);
        chk("to_err", err, 1);
        chk("to_hold", core_hold, 1);
        tick();
        chk("to_no_done", done_cnt - bd, 0);

        // Zero-length load: done pulse only, clears err
        br = ren_cnt; bd = done_cnt;
        start_load(0);
        chk("zero_done", done, 1);
        chk("zero_err", err, 0);
        chk("zero_hold", core_hold, 0);
        tick();
        chk("zero_ren", ren_cnt - br, 0);
        chk("zero_done_cnt", done_cnt - bd, 1);

        // Reset during WAIT of word 2 of 4; late source answer must be ignored
        src_lat = 3;
        start_load(4);
        k = 0;
        while (!(exIns_ren === 1'b1 && exIns_addr == 32'h8) && k < 100) begin tick(); k++; end
        chk("rstmid_reached", (k < 100) ? 1 : 0, 1);
        bw = wr_cnt; bd = done_cnt;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_hold", core_hold, 1);
        repeat (8) tick();
        chk("rstmid_writes", wr_cnt - bw, 0);
        chk("rstmid_done", done_cnt - bd, 0);

        // Oversized request saturates to the full memory
        src_lat = 1;
        bw = wr_cnt; bd = done_cnt;
        start_load(511);
        wait_idle(3000, "load511");
        tick();
        chk("sat_writes", wr_cnt - bw, 256);
        chk("sat_last_addr", last_wa, 255);
        chk("sat_done", done_cnt - bd, 1);
        chk("sat_mem255", imem_mem[255], 32'h19F);

        // Randomised traffic against the model
        src_lat = -1; src_fixed = 1'b0; src_spur = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            load_start = ($urandom_range(0, 11) == 0);
            load_words = ($urandom_range(0, 24) == 0) ? 9'($urandom_range(257, 511))
                                                      : 9'($urandom_range(0, 9));
            core_fetch_req  = $urandom_range(0, 1) == 1;
            core_fetch_addr = $urandom;
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end
        load_start = 1'b0; core_fetch_req = 1'b0; rst = 1'b0;
        wait_idle(3000, "random_drain");
        repeat (2) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/imem_load_ctrl.md
IMEM_LOAD_CTRL -- requirements
Module: imem_load_ctrl

Interface
REQ-001 SHALL have parameter IMEM_AW, default 8: instruction-memory word-address width (256 words).
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles per external word.
REQ-003 SHALL use a single clock and a reset that is synchronous and active-high.
REQ-004 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have port load_start  in  1  one-cycle pulse that starts an image load.
REQ-007 SHALL have port load_words  in  IMEM_AW+1  number of words to load; values above 2^IMEM_AW saturate to 2^IMEM_AW.
REQ-008 SHALL have port exIns_ren  out  1  one-cycle read request to the external source.
REQ-009 SHALL have port exIns_addr  out  32  byte address of the requested word (word index × 4).
REQ-010 SHALL have port exIns_valid  in  1  external word valid.
REQ-011 SHALL have port exIns_in  in  32  external word data.
REQ-012 SHALL have port core_fetch_req  in  1  core fetch request.
REQ-013 SHALL have port core_fetch_addr  in  32  byte PC; bits [IMEM_AW+1:2] are used.
REQ-014 SHALL have port core_fetch_ready  out  1  fetch accepted this cycle.
REQ-015 SHALL have port core_fetch_valid  out  1  fetch data valid.
REQ-016 SHALL have port core_fetch_data  out  32  instruction word.
REQ-017 SHALL have imem port outputs imem_en (1), imem_we (1), imem_addr (IMEM_AW), imem_wdata (32), and input imem_rdata (32) with 1-cycle read latency.
REQ-018 SHALL have status outputs core_hold, busy, done and err, each 1 bit.

Function
REQ-019 SHALL implement FSM states IDLE, REQ, WAIT, WRITE.
REQ-020 IDLE SHALL go to REQ on load_start when the saturated load_words is non-zero; with load_words=0 it SHALL stay in IDLE and pulse done for one cycle.
REQ-021 REQ SHALL assert exIns_ren for exactly one cycle with exIns_addr = idx×4, then go to WAIT; only one request SHALL be outstanding.
REQ-022 WAIT SHALL go to WRITE on exIns_valid and capture exIns_in; exIns_valid in any other state SHALL be ignored.
REQ-023 WRITE SHALL drive imem_en=1, imem_we=1, imem_addr=idx and imem_wdata=captured word, then increment idx and go to REQ, or to IDLE with a one-cycle done pulse after the last word.
REQ-024 idx SHALL start at 0 on each load; the imem address SHALL never wrap within a load.
REQ-025 core_fetch_ready SHALL equal (state==IDLE) && !load_start; a load_start in the same cycle as a fetch request SHALL win.
REQ-026 An accepted fetch SHALL drive imem_en=1, imem_we=0 and imem_addr=core_fetch_addr[IMEM_AW+1:2]; core_fetch_valid SHALL assert with core_fetch_data=imem_rdata exactly 1 cycle later.
REQ-027 busy SHALL be high whenever state != IDLE.
REQ-028 load_start SHALL be ignored while busy.
REQ-029 A WAIT cycle counter SHALL clear on entry; when it reaches TIMEOUT without exIns_valid, the block SHALL set err, return to IDLE, and not pulse done.
REQ-030 err SHALL remain high until the next accepted load_start.
REQ-031 core_hold SHALL set on accepted load_start and clear on the done pulse; it SHALL stay high after a timeout.

Reset
REQ-032 rst SHALL force state=IDLE and idx=0, clear the timeout counter, drive all outputs to 0 except core_hold=1, and take effect mid-load with no further imem write.

Structure
REQ-033 The state enum and the IMEM_AW/TIMEOUT defaults SHALL live in shared package imem_ctrl_pkg.
REQ-034 The timeout counter SHALL be a sub-module ld_timer (clear, enable, expired); everything else SHALL stay in one FSM.

Verification
REQ-035 load_words=4, source returns words 0xA0..0xA3 two cycles after each ren -> four writes to addresses 0..3, one done pulse, core_hold drops.
REQ-036 After load, fetch core_fetch_addr=0x8 -> core_fetch_valid next cycle with data 0xA2.
REQ-037 load_start and core_fetch_req in the same IDLE cycle -> core_fetch_ready=0, REQ entered next cycle.
REQ-038 With TIMEOUT=5 and no exIns_valid -> err=1 after 5 WAIT cycles, state IDLE, core_hold=1, no done.
REQ-039 rst during WAIT of word 2 of 4 -> IDLE next cycle, no imem write, core_hold=1; a late exIns_valid is ignored.
REQ-040 load_words=0 -> done pulse, no ren; load_words=511 with IMEM_AW=8 -> exactly 256 writes.
